fir_decim_requant: RTL and testbench

//  Sits directly downstream of the 16-tap FIR and consumes its full-precision y[n] (2*WIDTH, Q15 coeffs).

---
 rtl/fir_decim_requant.sv | 174 +++++++++++++++++
 tb/tb_fir_decim_requant.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_requant.sv
// fir_decim_requant
//   Takes the full-precision output of the upstream FIR, keeps one of every
//   DECIM accepted samples, rounds (half toward +inf) and saturates it down to
//   OUT_WIDTH, and queues the result in a show-ahead FIFO that drains through
//   a valid/ready handshake toward the DAC path.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (clears all state)
//   i_en       i_signal carries a valid FIR sample this cycle
//   i_signal   signed FIR output y[n], IN_WIDTH bits
//   i_clr_ovf  synchronous clear of o_overflow
//   o_data     signed FIFO head sample (0 when empty)
//   o_valid    FIFO non-empty
//   i_ready    consumer takes o_data; pop when o_valid && i_ready
//   o_sat      one-cycle pulse: a kept sample was clipped
//   o_overflow sticky: a kept sample was dropped because the FIFO was full
//   o_fill     current FIFO occupancy, 0..FIFO_DEPTH
module fir_decim_requant #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  input  logic [IN_WIDTH-1:0]           i_signal,
  input  logic                          i_clr_ovf,
  output logic [OUT_WIDTH-1:0]          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_sat,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill
);

  localparam int TW = IN_WIDTH + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  // Rounding constant and clip bounds, all expressed at the widened width.
  localparam logic signed [TW-1:0] RND  = TW'(1) << (SHIFT - 1);
  localparam logic signed [TW-1:0] MAXV =
    {{(TW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] MINV =
    {{(TW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------- decimation
  logic [PW-1:0] phase_reg;
  logic          keep;

  assign keep = i_en && (phase_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= '0;
    end else if (i_en) begin
      phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------- round/saturate
  // One extra bit of headroom so adding the rounding constant can never wrap.
  logic signed [TW-1:0]  t_ext;
  logic signed [TW-1:0]  r_shift;
  logic                  clip_hi;
  logic                  clip_lo;
  logic [OUT_WIDTH-1:0]  sat_val;

  assign t_ext   = $signed({i_signal[IN_WIDTH-1], i_signal}) + RND;
  assign r_shift = t_ext >>> SHIFT;
  assign clip_hi = r_shift > MAXV;
  assign clip_lo = r_shift < MINV;

  always_comb begin
    sat_val = r_shift[OUT_WIDTH-1:0];
    if (clip_hi) begin
      sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (clip_lo) begin
      sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  // Stage 1 register: loads only on kept samples; its valid drops back to 0
  // on any other cycle so an already-loaded sample drains into the FIFO
  // even while i_en is low.
  logic                 s1_valid_reg;
  logic [OUT_WIDTH-1:0] s1_data_reg;
  logic                 sat_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      sat_reg      <= 1'b0;
    end else begin
      s1_valid_reg <= keep;
      sat_reg      <= keep && (clip_hi || clip_lo);
      if (keep) begin
        s1_data_reg <= sat_val;
      end
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic                 ovf_reg;

  logic full;
  logic empty;
  logic pop;
  logic do_write;
  logic drop;

  assign full     = (count_reg == CNT_FULL);
  assign empty    = (count_reg == '0);
  assign pop      = !empty && i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_write = s1_valid_reg && (!full || pop);
  assign drop     = s1_valid_reg && full && !pop;

  // Storage carries no reset; o_data is gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= s1_data_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_write, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (drop) begin
      ovf_reg <= 1'b1;
    end else if (i_clr_ovf) begin
      ovf_reg <= 1'b0;
    end
  end

  assign o_valid    = !empty;
  assign o_data     = empty ? '0 : mem[rd_ptr_reg];
  assign o_fill     = count_reg;
  assign o_sat      = sat_reg;
  assign o_overflow = ovf_reg;

endmodule

// File: tb/tb_fir_decim_requant.sv
// Directed bench for fir_decim_requant: one instance decimating by 4 and one
// with no decimation share the stimulus; each step is checked against
// hand-computed values.
module tb_fir_decim_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] sig;
  logic        clr_ovf;
  logic        ready;

  logic [15:0] d4_data, d1_data;
  logic        d4_valid, d1_valid;
  logic        d4_sat, d1_sat;
  logic        d4_ovf, d1_ovf;
  logic [3:0]  d4_fill, d1_fill;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_decim_requant #(.DECIM(4)) u4 (
    .clk(clk), .rst(rst), .i_en(en), .i_signal(sig), .i_clr_ovf(clr_ovf),
    .o_data(d4_data), .o_valid(d4_valid), .i_ready(ready), .o_sat(d4_sat),
    .o_overflow(d4_ovf), .o_fill(d4_fill)
  );

  fir_decim_requant #(.DECIM(1)) u1 (
    .clk(clk), .rst(rst), .i_en(en), .i_signal(sig), .i_clr_ovf(clr_ovf),
    .o_data(d1_data), .o_valid(d1_valid), .i_ready(ready), .o_sat(d1_sat),
    .o_overflow(d1_ovf), .o_fill(d1_fill)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // DECIM=1 instance: apply one sample, check o_sat after the load edge and
  // the FIFO head after the write edge, then let it pop.
  task automatic apply_vec(input string tag, input logic [31:0] v,
                           input logic [15:0] exp_d, input logic exp_s);
    sig = v;
    en  = 1'b1;
    step();
    en  = 1'b0;
    check({tag, "_sat"}, 32'(d1_sat), 32'(exp_s));
    step();
    check({tag, "_valid"}, 32'(d1_valid), 32'd1);
    check({tag, "_data"}, 32'(d1_data), 32'(exp_d));
    step();
  endtask

  logic [15:0] got [$];

  initial begin
    rst = 1'b1; en = 1'b0; sig = '0; clr_ovf = 1'b0; ready = 1'b0;
    step();
    step();
    check("rst_valid4", 32'(d4_valid), 32'd0);
    check("rst_fill4",  32'(d4_fill),  32'd0);
    check("rst_data4",  32'(d4_data),  32'd0);
    check("rst_sat1",   32'(d1_sat),   32'd0);
    check("rst_ovf1",   32'(d1_ovf),   32'd0);
    rst = 1'b0;
    $display("reset state checked");

    // ---- 1: decimate-by-4 of ramp n<<15, n=0..11 -> 0,4,8
    ready = 1'b1;
    en    = 1'b1;
    for (int n = 0; n < 12; n++) begin
      sig = 32'(n) << 15;
      step();
      if (n == 0) check("t1_first_not_yet", 32'(d4_valid), 32'd0);
      if (n == 1) check("t1_first_valid", 32'(d4_valid), 32'd1);
      if (d4_valid) got.push_back(d4_data);
    end
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (d4_valid) got.push_back(d4_data);
    end
    check("t1_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("t1_out0", 32'(got[0]), 32'd0);
      check("t1_out1", 32'(got[1]), 32'd4);
      check("t1_out2", 32'(got[2]), 32'd8);
    end
    $display("decimation ramp: %0d outputs", got.size());

    // ---- 2/3: rounding and saturation on the DECIM=1 instance
    do_reset();
    ready = 1'b1;
    apply_vec("rnd_4000", 32'h00004000, 16'h0001, 1'b0);
    apply_vec("rnd_3fff", 32'h00003FFF, 16'h0000, 1'b0);
    apply_vec("rnd_c000", 32'hFFFFC000, 16'h0000, 1'b0);
    apply_vec("rnd_bfff", 32'hFFFFBFFF, 16'hFFFF, 1'b0);
    apply_vec("sat_pos",  32'h40000000, 16'h7FFF, 1'b1);
    apply_vec("sat_negmin", 32'hC0000000, 16'h8000, 1'b0);
    apply_vec("sat_max",  32'h7FFFFFFF, 16'h7FFF, 1'b1);
    $display("rounding/saturation vectors applied");

    // ---- 4: overfill with i_ready=0, then drain
    do_reset();
    ready = 1'b0;
    en    = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      sig = 32'(k) << 15;
      step();
    end
    en = 1'b0;
    step();
    check("t4_fill_full", 32'(d1_fill), 32'd8);
    check("t4_ovf_set",   32'(d1_ovf),  32'd1);
    ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      check($sformatf("t4_drain%0d", j), 32'(d1_data), 32'(j));
      step();
    end
    check("t4_empty_valid", 32'(d1_valid), 32'd0);
    check("t4_empty_fill",  32'(d1_fill),  32'd0);
    check("t4_ovf_sticky",  32'(d1_ovf),   32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t4_ovf_clr", 32'(d1_ovf), 32'd0);
    $display("overflow fill/drain done");

    // ---- 5: write into a full FIFO while popping
    ready = 1'b0;
    en    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sig = 32'(k) << 15;
      step();
    end
    en = 1'b0;
    step();
    check("t5_fill_full", 32'(d1_fill), 32'd8);
    en  = 1'b1;
    sig = 32'd9 << 15;
    step();
    en    = 1'b0;
    ready = 1'b1;
    check("t5_head", 32'(d1_data), 32'd1);
    step();
    check("t5_fill_hold", 32'(d1_fill), 32'd8);
    check("t5_no_ovf",    32'(d1_ovf),  32'd0);
    for (int j = 2; j <= 9; j++) begin
      check($sformatf("t5_order%0d", j), 32'(d1_data), 32'(j));
      step();
    end
    check("t5_empty", 32'(d1_valid), 32'd0);
    $display("full write+pop done");

    // ---- 6: async reset with 3 entries queued
    ready = 1'b0;
    en    = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      sig = 32'(k) << 15;
      step();
    end
    en = 1'b0;
    step();
    check("t6_fill3", 32'(d1_fill), 32'd3);
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(d1_valid), 32'd0);
    check("t6_async_fill",  32'(d1_fill),  32'd0);
    check("t6_async_data",  32'(d1_data),  32'd0);
    step();
    rst = 1'b0;
    en  = 1'b1;
    sig = 32'd5 << 15;
    step();
    en = 1'b0;
    step();
    check("t6_first_kept_valid", 32'(d4_valid), 32'd1);
    check("t6_first_kept_data",  32'(d4_data),  32'd5);
    $display("async reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
